// File: rtl/adc_spi_sampler_pkg.sv
// Shared fan-control defines: fan controller constants, sampler FSM encodings
// and a small width helper.
package adc_spi_sampler_pkg;

    // Fan controller operating point; the sampler defaults track these.
    localparam int FAN_ADC_BITWIDTH  = 4;
    localparam int FAN_RAW_BITWIDTH  = 8;
    localparam int FAN_SCLK_DIV      = 2;
    localparam int FAN_SAMPLE_PERIOD = 1000;

    // Sampler FSM encodings (kept as plain constants for legacy tools).
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Registered SPI pin pair.
    typedef struct packed {
        logic cs_n;
        logic sclk;
    } spi_pins_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_spi_sampler_spi_clk_div.sv
// SCLK half-period timer: counts clk_en_i ticks and pulses half_done on the
// tick that completes a half-period. restart holds the count at zero.
module spi_clk_div
    import adc_spi_sampler_pkg::*;
#(
    parameter int SCLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic clk_en_i,
    input  logic restart,
    output logic half_done
);

    localparam int            CW       = cnt_w(SCLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign half_done = clk_en_i && !restart && (cnt == CNT_LAST);

    // Tick counter, wraps at the end of each half-period.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else if (clk_en_i) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/adc_spi_sampler.sv
// SPI ADC sampler for the fan controller: reads RAW_BITWIDTH bits MSB first
// (mode 0), rounds/saturates to ADC_BITWIDTH and strobes the result.
// ADC_value_o / dataVaild_STRB_o feed the fan controller's ADC value and
// data-valid strobe inputs.
module adc_spi_sampler
    import adc_spi_sampler_pkg::*;
#(
    parameter int ADC_BITWIDTH  = FAN_ADC_BITWIDTH,
    parameter int RAW_BITWIDTH  = FAN_RAW_BITWIDTH,
    parameter int SCLK_DIV      = FAN_SCLK_DIV,
    parameter int SAMPLE_PERIOD = FAN_SAMPLE_PERIOD
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    clk_en_i,
    input  logic                    trigger_i,
    input  logic                    spi_miso_i,
    output logic                    spi_cs_n_o,
    output logic                    spi_sclk_o,
    output logic [ADC_BITWIDTH-1:0] ADC_value_o,
    output logic                    dataVaild_STRB_o,
    output logic                    busy_o
);

    localparam int SHIFT_AMT = RAW_BITWIDTH - ADC_BITWIDTH;
    localparam int PW        = cnt_w(SAMPLE_PERIOD);
    localparam int BW        = cnt_w(RAW_BITWIDTH);

    localparam logic [PW-1:0]         PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);
    localparam logic [BW-1:0]         BIT_LAST    = BW'(RAW_BITWIDTH - 1);
    localparam logic [RAW_BITWIDTH:0] ROUND_HALF  = (RAW_BITWIDTH+1)'(2**(SHIFT_AMT-1));
    localparam logic [RAW_BITWIDTH:0] SAT_MAX     = (RAW_BITWIDTH+1)'(2**ADC_BITWIDTH - 1);

    // Round to nearest, then clamp; the extra sum bit keeps the top codes
    // from wrapping to zero.
    function automatic logic [ADC_BITWIDTH-1:0] reduce_raw(input logic [RAW_BITWIDTH-1:0] raw);
        logic [RAW_BITWIDTH:0] q;
        q = ({1'b0, raw} + ROUND_HALF) >> SHIFT_AMT;
        if (q > SAT_MAX) reduce_raw = SAT_MAX[ADC_BITWIDTH-1:0];
        else             reduce_raw = q[ADC_BITWIDTH-1:0];
    endfunction

    logic [2:0]              state, state_nxt;
    spi_pins_t               pins;
    logic [BW-1:0]           bit_cnt;
    logic [RAW_BITWIDTH-1:0] shreg;
    logic [PW-1:0]           per_cnt;
    logic                    pending;
    logic [ADC_BITWIDTH-1:0] adc_value;
    logic                    strb;

    logic period_hit, new_req, start, leave_idle, half_done, last_edge;

    assign period_hit = clk_en_i && (per_cnt == PERIOD_LAST);
    // Period hit and trigger in one cycle collapse into a single request.
    assign new_req    = period_hit || trigger_i;
    assign start      = new_req || pending;
    assign leave_idle = (state == ST_IDLE) && start;
    // In SHIFT the registered SCLK level doubles as the bit phase.
    assign last_edge  = (state == ST_SHIFT) && half_done && pins.sclk && (bit_cnt == BIT_LAST);

    spi_clk_div #(
        .SCLK_DIV (SCLK_DIV)
    ) u_clk_div (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .clk_en_i  (clk_en_i),
        .restart   (state == ST_IDLE),
        .half_done (half_done)
    );

    // Free-running sample period counter, advances on ticks only.
    always_ff @(posedge clk_i) begin
        if (!rstn_i)       per_cnt <= '0;
        else if (clk_en_i) per_cnt <= (per_cnt == PERIOD_LAST) ? '0 : per_cnt + 1'b1;
    end

    // Next-state decode; leaving IDLE never waits for a tick.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start)     state_nxt = ST_SETUP;
            ST_SETUP: if (half_done) state_nxt = ST_SHIFT;
            ST_SHIFT: if (last_edge) state_nxt = ST_HOLD;
            ST_HOLD:  if (half_done) state_nxt = ST_DONE;
            ST_DONE:                 state_nxt = ST_IDLE;
            default:                 state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // SPI pins are flops so they stay glitch-free and hold between ticks.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            pins.cs_n <= 1'b1;
            pins.sclk <= 1'b0;
        end else begin
            pins.cs_n <= !((state_nxt == ST_SETUP) || (state_nxt == ST_SHIFT));
            if (state == ST_SHIFT) begin
                if (half_done) pins.sclk <= !pins.sclk;
            end else begin
                pins.sclk <= 1'b0;
            end
        end
    end

    // Shift register and bit counter: capture MISO on the SCLK rising tick,
    // advance the bit on the falling tick.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (leave_idle) begin
            bit_cnt <= '0;
        end else if ((state == ST_SHIFT) && half_done) begin
            if (!pins.sclk)                shreg   <= {shreg[RAW_BITWIDTH-2:0], spi_miso_i};
            else if (bit_cnt != BIT_LAST)  bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // One-deep pending request: set by requests while busy, consumed on
    // leaving IDLE; extra requests while already pending are dropped.
    always_ff @(posedge clk_i) begin
        if (!rstn_i)                              pending <= 1'b0;
        else if (leave_idle)                      pending <= 1'b0;
        else if ((state != ST_IDLE) && new_req)   pending <= 1'b1;
    end

    // Result register and single-cycle strobe on leaving DONE.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            adc_value <= '0;
            strb      <= 1'b0;
        end else begin
            strb <= 1'b0;
            if (state == ST_DONE) begin
                adc_value <= reduce_raw(shreg);
                strb      <= 1'b1;
            end
        end
    end

    assign spi_cs_n_o       = pins.cs_n;
    assign spi_sclk_o       = pins.sclk;
    assign ADC_value_o      = adc_value;
    assign dataVaild_STRB_o = strb;
    assign busy_o           = (state != ST_IDLE);

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Directed bench for adc_spi_sampler with a behavioural MSB-first ADC model.
module tb_adc_spi_sampler;

    localparam int RAW_W = 8;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       clk_en = 1'b1;
    logic       trigger = 1'b0;
    logic       miso;
    logic       cs_n, sclk, strb, busy;
    logic [3:0] val;

    always #5 clk = ~clk;

    adc_spi_sampler dut (
        .clk_i            (clk),
        .rstn_i           (rstn),
        .clk_en_i         (clk_en),
        .trigger_i        (trigger),
        .spi_miso_i       (miso),
        .spi_cs_n_o       (cs_n),
        .spi_sclk_o       (sclk),
        .ADC_value_o      (val),
        .dataVaild_STRB_o (strb),
        .busy_o           (busy)
    );

    // ADC model: presents bit idx (MSB first), advances after each SCLK rise.
    logic [RAW_W-1:0] adc_word = '0;
    int               idx = 0;
    always @(posedge sclk or posedge cs_n) begin
        if (cs_n) idx <= 0;
        else      idx <= idx + 1;
    end
    assign miso = (idx < RAW_W) ? adc_word[RAW_W-1-idx] : 1'b0;

    // Monitors.
    int cyc = 0, rises = 0;
    int strb_cnt = 0, strb_wide = 0, cs_low = 0, sclk_hi = 0, cs_fall = 0;
    logic prev_cs = 1'b1, prev_strb = 1'b0;
    int strb_q[$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge sclk) rises <= rises + 1;
    always @(negedge clk) begin
        if (strb === 1'b1) begin
            strb_cnt <= strb_cnt + 1;
            strb_q.push_back(cyc);
            if (prev_strb === 1'b1) strb_wide <= strb_wide + 1;
        end
        if (cs_n === 1'b0) cs_low <= cs_low + 1;
        if (sclk === 1'b1) sclk_hi <= sclk_hi + 1;
        if (cs_n === 1'b0 && prev_cs === 1'b1) cs_fall <= cyc;
        prev_cs   <= cs_n;
        prev_strb <= strb;
    end

    int total = 0, bad = 0;
    bit div4 = 1'b0;
    int trig_cyc, sb, rb, cb, hb, wb, rst_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next falling edge; drive clk_en there.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            clk_en = div4 ? (cyc % 4 == 0) : 1'b1;
            #1;
        end
    endtask

    task automatic snap();
        sb = strb_cnt; rb = rises; cb = cs_low; hb = sclk_hi; wb = strb_wide;
    endtask

    task automatic pulse_trig();
        trigger = 1'b1;
        step(1);
        trigger = 1'b0;
        trig_cyc = cyc;
    endtask

    task automatic wait_strb(input int n, input int budget);
        for (int i = 0; i < budget && strb_cnt < sb + n; i++) step(1);
    endtask

    function automatic int strb_at(input int k);
        return (strb_q.size() > k) ? strb_q[k] : -1;
    endfunction

    task automatic do_reset();
        rstn = 1'b0;
        step(1);
        chk("rst_cs", cs_n, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_val", val, 0);
        chk("rst_strb", strb, 0);
        chk("rst_busy", busy, 0);
        rstn = 1'b1;
        step(2);
    endtask

    task automatic conv(input logic [7:0] word, input int expv);
        adc_word = word;
        snap();
        pulse_trig();
        chk("busy_run", busy, 1);
        wait_strb(1, 300);
        step(3);
        chk("val", val, expv);
        chk("nstrb", strb_cnt - sb, 1);
        chk("lat", strb_at(sb) - trig_cyc, 37);
        chk("rises", rises - rb, 8);
        chk("cs_low", cs_low - cb, 34);
        chk("sclk_hi", sclk_hi - hb, 16);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        do_reset();

        // Rounding and saturation.
        conv(8'h17, 1);
        conv(8'h18, 2);
        conv(8'hF8, 15);
        conv(8'h00, 0);

        // Requests while busy: one queued, the extra one dropped.
        do_reset();
        adc_word = 8'h17;
        snap();
        pulse_trig();
        step(10);
        pulse_trig();
        step(10);
        pulse_trig();
        wait_strb(2, 300);
        step(150);
        chk("pend_nstrb", strb_cnt - sb, 2);
        chk("pend_gap", strb_at(sb + 1) - strb_at(sb), 38);
        chk("pend_rises", rises - rb, 16);
        chk("pend_val", val, 1);

        // Tick every 4th cycle: phases scale by 4, strobe stays 1 cycle.
        do_reset();
        div4 = 1'b1;
        adc_word = 8'h18;
        for (int i = 0; i < 8 && (cyc % 4) != 0; i++) step(1);
        snap();
        pulse_trig();
        wait_strb(1, 800);
        step(5);
        chk("d4_nstrb", strb_cnt - sb, 1);
        chk("d4_wide", strb_wide - wb, 0);
        chk("d4_lat", strb_at(sb) - trig_cyc, 145);
        chk("d4_cs_low", cs_low - cb, 136);
        chk("d4_sclk_hi", sclk_hi - hb, 64);
        chk("d4_val", val, 2);
        div4 = 1'b0;
        step(1);

        // Reset in the middle of SHIFT.
        adc_word = 8'hF8;
        snap();
        pulse_trig();
        for (int i = 0; i < 100 && rises < rb + 3; i++) step(1);
        step(2);
        rstn = 1'b0;
        step(1);
        rst_cyc = cyc;
        chk("mid_cs", cs_n, 1);
        chk("mid_sclk", sclk, 0);
        chk("mid_busy", busy, 0);
        chk("mid_val", val, 0);
        rstn = 1'b1;
        snap();
        step(100);
        chk("mid_nstrb", strb_cnt - sb, 0);
        chk("mid_val2", val, 0);
        for (int i = 0; i < 1200 && cs_fall <= rst_cyc; i++) step(1);
        chk("auto_first", cs_fall - rst_cyc, 1000);

        // Free run: strobes one period apart.
        wait_strb(11, 12000);
        chk("run_first", strb_at(sb) - rst_cyc, 1037);
        for (int i = 0; i < 10; i++)
            chk("run_gap", strb_at(sb + i + 1) - strb_at(sb + i), 1000);
        chk("run_wide", strb_wide - wb, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_spi_sampler.md
ADC_SPI_SAMPLER -- requirements
Module: adc_spi_sampler

Interface
REQ-001 SHALL have parameter ADC_BITWIDTH, default 4, the width of the output sample fed to the fan controller.
REQ-002 SHALL have parameter RAW_BITWIDTH, default 8, the number of bits read from the external ADC per conversion; legal when RAW_BITWIDTH > ADC_BITWIDTH.
REQ-003 SHALL have parameter SCLK_DIV, default 2, the SCLK half-period in clk_en_i ticks; legal when >= 1.
REQ-004 SHALL have parameter SAMPLE_PERIOD, default 1000, the auto-trigger interval in clk_en_i ticks; legal when >= 2*SCLK_DIV*(RAW_BITWIDTH+1).
REQ-005 SHALL have clk_i, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have rstn_i, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have clk_en_i, input, 1 bit: timing tick; all SPI timing and the period counter advance only in cycles where it is high.
REQ-008 SHALL have trigger_i, input, 1 bit: manual conversion request, sampled every clk_i cycle.
REQ-009 SHALL have spi_miso_i, input, 1 bit: ADC serial data, MSB first.
REQ-010 SHALL have spi_cs_n_o, output, 1 bit: ADC chip select, active low.
REQ-011 SHALL have spi_sclk_o, output, 1 bit: SPI clock, mode 0, idle low.
REQ-012 SHALL have ADC_value_o, output, ADC_BITWIDTH bits: last reduced sample, held between updates.
REQ-013 SHALL have dataVaild_STRB_o, output, 1 bit: one-clk_i-cycle pulse when ADC_value_o updates.
REQ-014 SHALL have busy_o, output, 1 bit: high in every state except IDLE.

Function
REQ-015 SHALL implement the states IDLE, SETUP, SHIFT, HOLD and DONE.
REQ-016 IDLE: CS high, SCLK low; a start is requested when the period counter reaches SAMPLE_PERIOD-1 on a tick, when trigger_i is high, or when the pending flag is set; IDLE SHALL move to SETUP on the next clk_i edge, without waiting for a tick.
REQ-017 Period counter: counts ticks modulo SAMPLE_PERIOD, free-running regardless of state.
REQ-018 SETUP: CS low, SCLK low, lasting SCLK_DIV ticks, then SHIFT.
REQ-019 SHIFT, per bit: SCLK low for SCLK_DIV ticks, then high for SCLK_DIV ticks; spi_miso_i is captured into the shift register on the tick that drives SCLK high.
REQ-020 SHIFT SHALL move to HOLD after RAW_BITWIDTH bits, with SCLK low on entry to HOLD.
REQ-021 HOLD: CS high, SCLK low, lasting SCLK_DIV ticks, then DONE.
REQ-022 DONE: lasts exactly one clk_i cycle; on exit ADC_value_o is updated, dataVaild_STRB_o is high for that one cycle, and the block returns to IDLE.
REQ-023 With defaults and clk_en_i held high: CS is low for exactly 34 cycles; the strobe occurs 37 cycles after leaving IDLE.
REQ-024 Reduction: ADC_value_o = min((raw + 2^(RAW_BITWIDTH-ADC_BITWIDTH-1)) >> (RAW_BITWIDTH-ADC_BITWIDTH), 2^ADC_BITWIDTH-1); the sum is computed one bit wider than raw, with no wrap.
REQ-025 A start request arriving while busy_o is high SHALL set a one-deep pending flag; further requests while pending are dropped.
REQ-026 The pending flag SHALL be cleared on the transition IDLE->SETUP.
REQ-027 A period hit and trigger_i in the same cycle SHALL count as one request.
REQ-028 If clk_en_i is low, SPI outputs SHALL hold their values, with no glitches.

Reset
REQ-029 While rstn_i is low at a clk_i edge, the outputs SHALL be: spi_cs_n_o=1, spi_sclk_o=0, ADC_value_o=0, dataVaild_STRB_o=0, busy_o=0.
REQ-030 Reset SHALL clear state to IDLE, and SHALL clear the period counter, the tick counter, the bit counter, the shift register and the pending flag.
REQ-031 Reset mid-conversion SHALL abort it, raise CS on the same edge, emit no strobe and leave no pending request.

Structure
REQ-032 State encodings SHALL live in the shared fan-control defines package, alongside the fan controller's constants.
REQ-033 Tick counting for SCLK half-periods SHALL be one sub-module, spi_clk_div: input clk_en_i and restart, output a half-period-done pulse.
REQ-034 The top-level integration SHALL connect ADC_value_o and dataVaild_STRB_o to the fan controller's ADC value and data-valid strobe inputs.

Verification
REQ-035 Defaults, clk_en_i=1, ADC model returning 0x17, trigger_i pulse -> 8 SCLK rising edges; ADC_value_o=1; one strobe, 37 cycles after the trigger.
REQ-036 ADC model returning 0x18 -> ADC_value_o=2; returning 0xF8 -> ADC_value_o=15 (saturated); returning 0x00 -> ADC_value_o=0.
REQ-037 trigger_i pulsed twice during one conversion -> exactly two conversions back to back, with no strobe lost or duplicated.
REQ-038 clk_en_i high every 4th cycle -> all SPI phase lengths scale by 4; the strobe is still exactly 1 clk_i cycle wide.
REQ-039 rstn_i low for one cycle during SHIFT bit 3 -> CS high on the next edge; no strobe; ADC_value_o=0; the next auto-trigger fires SAMPLE_PERIOD ticks after reset.
REQ-040 Free run, SAMPLE_PERIOD=1000 -> strobes exactly 1000 ticks apart over 10 periods.
